fm_sb_gearbox: RTL and testbench
================================

FM_SB_GEARBOX -- requirements
Module: fm_sb_gearbox

Interface
REQ-001 SHALL have parameter SB_DW, default 51, meaning width of one monitored sample in bits (1..256).
REQ-002 SHALL have parameter AXI_DW, default 32, meaning readout beat width in bits.
REQ-003 SHALL have parameter DEPTH, default 16, meaning sample buffer depth in entries (power of two, >= 2).
REQ-004 SHALL have port spy_clock  in  1  single clock for all logic.
REQ-005 SHALL have port spy_resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port pb_mode  in  2  00 disabled, 01 continuous, 10 triggered, 11 treated as 00.
REQ-007 SHALL have port fm_data  in  SB_DW  monitored sample.
REQ-008 SHALL have port fm_vld  in  1  sample valid.
REQ-009 SHALL have port trig  in  1  single-cycle capture trigger, used in triggered mode only.
REQ-010 SHALL have port axi_data  out  AXI_DW  readout beat.
REQ-011 SHALL have port axi_vld  out  1  readout beat valid.
REQ-012 SHALL have port axi_last  out  1  asserted on the final beat of a sample.
REQ-013 SHALL have port axi_rdy  in  1  readout beat accepted when high together with axi_vld.
REQ-014 SHALL have port fill  out  clog2(DEPTH)+1  number of stored samples.
REQ-015 SHALL have port frozen  out  1  high while state is FROZEN.

Function
REQ-016 SHALL define NW = ceil(SB_DW/AXI_DW) beats per sample; beat k carries sample bits [k*AXI_DW +: AXI_DW], with bits above SB_DW zero-padded on the last beat.
REQ-017 SHALL implement states IDLE, ARMED, CAPTURE, FROZEN; pb_mode 01 selects CAPTURE, 10 selects ARMED, 00/11 selects IDLE.
REQ-018 SHALL write fm_data when fm_vld=1 only in CAPTURE, and only when the buffer is not full.
REQ-019 SHALL treat full as a pre-pop condition: a write arriving while full is dropped, even if a pop occurs in the same cycle.
REQ-020 SHALL in ARMED move to CAPTURE on trig=1; the sample presented in the trig cycle with fm_vld=1 is written.
REQ-021 SHALL in triggered mode move CAPTURE to FROZEN on the cycle fill reaches DEPTH, and FROZEN to ARMED on the cycle the last beat of the last stored sample is accepted.
REQ-022 SHALL in continuous mode never enter FROZEN and shall ignore trig.
REQ-023 SHALL assert axi_vld whenever fill>0, and advance the beat counter on axi_vld and axi_rdy, popping the sample on acceptance of beat NW-1 (axi_last=1).
REQ-024 SHALL have axi_vld high the cycle after a write into an empty buffer (one-cycle latency).
REQ-025 SHALL hold axi_data and axi_last stable while axi_vld=1 and axi_rdy=0.
REQ-026 SHALL handle simultaneous write and pop with fill unchanged, and wrap read and write pointers modulo DEPTH.
REQ-027 SHALL on any pb_mode change flush the buffer, clear the beat counter and enter the new mode's state on the next cycle; a write in the change cycle is discarded.
REQ-028 SHALL in IDLE hold the buffer empty.

Reset
REQ-029 SHALL on spy_resetn=0 set state IDLE, pointers, fill and beat counter to 0, and axi_vld, axi_last, frozen, axi_data to 0.
REQ-030 SHALL abandon a partially read sample when reset is asserted mid-readout; that sample is not re-delivered.

Configuration
REQ-031 SHALL with FM_SB_OVF_CNT_EN defined provide output ovf_cnt (16 bits, reset 0), incrementing once per dropped write in CAPTURE, saturating at 0xFFFF, and not cleared by mode changes.
REQ-032 SHALL without FM_SB_OVF_CNT_EN omit the ovf_cnt port and its logic entirely.

Structure
REQ-033 SHALL place pb_mode encodings, the state enum and the NW ceiling function in the shared fast-monitoring spy-buffer package.
REQ-034 SHALL use one sub-module, fm_sb_fifo (DEPTH x SB_DW storage, pointers, fill), with the beat serialiser and state machine in fm_sb_gearbox.

Verification
REQ-035 SHALL cover continuous mode, SB_DW=51, AXI_DW=32, axi_rdy=1: sample 0x7_FFFF_1234_5678 gives beats 0x12345678 and 0x0007FFFF with axi_last on the second beat.
REQ-036 SHALL cover triggered mode, DEPTH=16: fm_vld held high and trig pulsed at cycle 10 gives exactly 16 samples captured, frozen=1, and return to ARMED after 32 accepted beats.
REQ-037 SHALL cover continuous mode, axi_rdy=0, 20 writes: fill=16 and, with FM_SB_OVF_CNT_EN, ovf_cnt=4.
REQ-038 SHALL cover full buffer with a simultaneous pop and write: the write is dropped and fill becomes 15.
REQ-039 SHALL cover pb_mode switching 01->00 with fill=5: fill=0 and axi_vld=0 on the next cycle.
REQ-040 SHALL cover spy_resetn asserted during beat 0 of 2: all outputs are 0, and after release the next sample starts at beat 0.

Source files
------------

// File: rtl/fm_sb_pkg.sv
// Shared fast-monitoring spy-buffer definitions: pb_mode encodings, capture states and
// the beats-per-sample helper.
package fm_sb_pkg;

  typedef enum logic [1:0] {
    PbOff  = 2'b00,
    PbCont = 2'b01,
    PbTrig = 2'b10,
    PbRsvd = 2'b11
  } pb_mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StCapture,
    StFrozen
  } sb_state_e;

  function automatic int unsigned fm_sb_nw(input int unsigned sb_dw, input int unsigned axi_dw);
    return (sb_dw + axi_dw - 1) / axi_dw;
  endfunction

  // Reserved encoding behaves as disabled.
  function automatic sb_state_e fm_sb_mode_state(input logic [1:0] mode);
    case (mode)
      PbCont:  return StCapture;
      PbTrig:  return StArmed;
      default: return StIdle;
    endcase
  endfunction

endpackage

// File: rtl/fm_sb_fifo.sv
// Sample store for the spy buffer: Depth x Width circular buffer with wrapping pointers
// and an occupancy count. A push while full is dropped even if a pop happens alongside.
module fm_sb_fifo #(
  parameter int unsigned Width = 51,
  parameter int unsigned Depth = 16,
  localparam int unsigned Aw   = $clog2(Depth),
  localparam int unsigned Fw   = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic [Fw-1:0]    fill_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Fw-1:0]    fill_q, fill_d;
  logic             push_ok, pop_ok;

  always_comb begin
    full_o  = fill_q == Fw'(Depth);
    empty_o = fill_q == '0;
    push_ok = push_i && !full_o && !flush_i;
    pop_ok  = pop_i && !empty_o && !flush_i;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    fill_d  = fill_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      fill_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
      fill_d = fill_q + Fw'(push_ok) - Fw'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fill_q <= fill_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

  assign data_o = mem_q[rptr_q];
  assign fill_o = fill_q;

endmodule

// File: rtl/fm_sb_gearbox.sv
// Spy buffer front end: captures monitored samples in continuous or triggered mode and
// serialises each into AXI_DW beats. Optional overflow counter: FM_SB_OVF_CNT_EN.
module fm_sb_gearbox
  import fm_sb_pkg::*;
#(
  parameter int unsigned SB_DW  = 51,
  parameter int unsigned AXI_DW = 32,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned FW    = $clog2(DEPTH) + 1
) (
  input  logic              spy_clock,
  input  logic              spy_resetn,
  input  logic [1:0]        pb_mode,
  input  logic [SB_DW-1:0]  fm_data,
  input  logic              fm_vld,
  input  logic              trig,
  output logic [AXI_DW-1:0] axi_data,
  output logic              axi_vld,
  output logic              axi_last,
  input  logic              axi_rdy,
  output logic [FW-1:0]     fill,
  output logic              frozen
`ifdef FM_SB_OVF_CNT_EN
  ,
  output logic [15:0]       ovf_cnt
`endif
);

  localparam int unsigned NW = fm_sb_nw(SB_DW, AXI_DW);
  localparam int unsigned BW = (NW > 1) ? $clog2(NW) : 1;

  sb_state_e           state_q, state_d;
  logic [1:0]          mode_q;
  logic [BW-1:0]       beat_q, beat_d;
  logic                mode_chg, flush, wr_req, push, pop, full, empty;
  logic                last_beat, accept, fill_to_full;
  logic [SB_DW-1:0]    rd_data;
  logic [NW*AXI_DW-1:0] rd_pad;

  assign mode_chg = pb_mode != mode_q;

  fm_sb_fifo #(
    .Width (SB_DW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (spy_clock),
    .rst_ni  (spy_resetn),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (fm_data),
    .pop_i   (pop),
    .data_o  (rd_data),
    .fill_o  (fill),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge spy_clock or negedge spy_resetn) begin
    if (!spy_resetn) begin
      state_q <= StIdle;
      mode_q  <= PbOff;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= pb_mode;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    if (mode_chg) begin
      state_d = fm_sb_mode_state(pb_mode);
      beat_d  = '0;
    end else begin
      if (accept) beat_d = last_beat ? '0 : beat_q + 1'b1;
      case (state_q)
        StArmed:   if (trig) state_d = StCapture;
        StCapture: if (mode_q == PbTrig && fill_to_full) state_d = StFrozen;
        StFrozen:  if (pop && fill == FW'(1)) state_d = StArmed;
        default:   ;
      endcase
    end
  end

  always_comb begin
    wr_req = 1'b0;
    case (state_q)
      StCapture: wr_req = fm_vld;
      StArmed:   wr_req = fm_vld && trig;
      default:   ;
    endcase
    wr_req    = wr_req && !mode_chg;
    flush     = mode_chg || state_q == StIdle;
    push      = wr_req && !full;
    axi_vld   = !empty;
    last_beat = beat_q == BW'(NW - 1);
    axi_last  = axi_vld && last_beat;
    accept    = axi_vld && axi_rdy;
    pop       = accept && last_beat && !mode_chg;
    // Full test uses the pre-pop count, so a simultaneous pop cannot make room.
    fill_to_full = (fill == FW'(DEPTH)) || (fill == FW'(DEPTH - 1) && push && !pop);
    rd_pad              = '0;
    rd_pad[SB_DW-1:0]   = rd_data;
    axi_data = axi_vld ? rd_pad[beat_q*AXI_DW +: AXI_DW] : '0;
    frozen   = state_q == StFrozen;
  end

`ifdef FM_SB_OVF_CNT_EN
  logic [15:0] ovf_q;

  always_ff @(posedge spy_clock or negedge spy_resetn) begin
    if (!spy_resetn) begin
      ovf_q <= '0;
    end else if (wr_req && full && state_q == StCapture && ovf_q != 16'hFFFF) begin
      ovf_q <= ovf_q + 16'd1;
    end
  end

  assign ovf_cnt = ovf_q;
`endif

endmodule

// File: tb/tb_fm_sb_gearbox.sv
// Bench for fm_sb_gearbox: queue-based reference model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_fm_sb_gearbox;

  localparam int unsigned SB_DW  = 51;
  localparam int unsigned AXI_DW = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned NW     = 2;
  localparam int unsigned FW     = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        pb_mode = 2'b00;
  logic [SB_DW-1:0]  fm_data = '0;
  logic              fm_vld = 1'b0;
  logic              trig = 1'b0;
  logic              axi_rdy = 1'b0;
  logic [AXI_DW-1:0] axi_data;
  logic              axi_vld, axi_last, frozen;
  logic [FW-1:0]     fill;
`ifdef FM_SB_OVF_CNT_EN
  logic [15:0]       ovf_cnt;
`endif

  always #5 clk = ~clk;

  fm_sb_gearbox #(
    .SB_DW  (SB_DW),
    .AXI_DW (AXI_DW),
    .DEPTH  (DEPTH)
  ) dut (
    .spy_clock  (clk),
    .spy_resetn (rst_n),
    .pb_mode    (pb_mode),
    .fm_data    (fm_data),
    .fm_vld     (fm_vld),
    .trig       (trig),
    .axi_data   (axi_data),
    .axi_vld    (axi_vld),
    .axi_last   (axi_last),
    .axi_rdy    (axi_rdy),
    .fill       (fill),
    .frozen     (frozen)
`ifdef FM_SB_OVF_CNT_EN
    ,
    .ovf_cnt    (ovf_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sample queue, beat index, mode and capture state (0 idle, 1 armed,
  // 2 capture, 3 frozen).
  logic [SB_DW-1:0] q[$];
  int               m_beat = 0;
  int               m_state = 0;
  logic [1:0]       m_mode = 2'b00;
  int               m_ovf = 0;

  always @(posedge clk or negedge rst_n) begin
    bit acc, lst, pop, full, wr;
    if (!rst_n) begin
      q.delete();
      m_beat  = 0;
      m_state = 0;
      m_mode  = 2'b00;
      m_ovf   = 0;
    end else if (pb_mode != m_mode) begin
      q.delete();
      m_beat  = 0;
      m_mode  = pb_mode;
      m_state = (pb_mode == 2'b01) ? 2 : (pb_mode == 2'b10) ? 1 : 0;
    end else begin
      lst  = m_beat == NW - 1;
      acc  = q.size() > 0 && axi_rdy;
      pop  = acc && lst;
      full = q.size() == DEPTH;
      wr   = fm_vld && (m_state == 2 || (m_state == 1 && trig));
      if (acc) m_beat = lst ? 0 : m_beat + 1;
      if (pop) void'(q.pop_front());
      if (wr && !full) q.push_back(fm_data);
      else if (wr && m_state == 2 && m_ovf < 65535) m_ovf++;
      if (m_state == 1 && trig) m_state = 2;
      else if (m_state == 2 && m_mode == 2'b10 && q.size() == DEPTH) m_state = 3;
      else if (m_state == 3 && pop && q.size() == 0) m_state = 1;
    end
  end

  always @(negedge clk) begin
    logic [AXI_DW-1:0] ed;
    bit ev;
    ev = q.size() > 0;
    ed = ev ? AXI_DW'(q[0] >> (m_beat * AXI_DW)) : '0;
    chk("model_fill", 64'(fill), 64'(q.size()));
    chk("model_vld", 64'(axi_vld), 64'(ev));
    chk("model_data", 64'(axi_data), 64'(ed));
    chk("model_last", 64'(axi_last), 64'(ev && m_beat == NW - 1));
    chk("model_frozen", 64'(frozen), 64'(m_state == 3));
`ifdef FM_SB_OVF_CNT_EN
    chk("model_ovf", 64'(ovf_cnt), 64'(m_ovf));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, beats;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("rst_fill", 64'(fill), 0);
    chk("rst_vld", 64'(axi_vld), 0);
    chk("rst_data", 64'(axi_data), 0);
    chk("rst_frozen", 64'(frozen), 0);

    // Continuous mode, single sample split into two beats.
    pb_mode = 2'b01;
    step();
    fm_data = 51'h7_FFFF_1234_5678;
    fm_vld  = 1'b1;
    axi_rdy = 1'b1;
    step();
    fm_vld = 1'b0;
    chk("c_beat0_vld", 64'(axi_vld), 1);
    chk("c_beat0_data", 64'(axi_data), 64'h1234_5678);
    chk("c_beat0_last", 64'(axi_last), 0);
    step();
    chk("c_beat1_data", 64'(axi_data), 64'h0007_FFFF);
    chk("c_beat1_last", 64'(axi_last), 1);
    step();
    chk("c_empty", 64'(axi_vld), 0);

    // 20 writes with readout stalled.
    axi_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      fm_data = SB_DW'({32'hA500_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)});
      fm_vld  = 1'b1;
      step();
    end
    fm_vld = 1'b0;
    chk("ovf_fill16", 64'(fill), 16);
`ifdef FM_SB_OVF_CNT_EN
    chk("ovf_cnt4", 64'(ovf_cnt), 4);
`endif

    // Full buffer: pop and write in the same cycle drops the write.
    axi_rdy = 1'b1;
    step();
    chk("full_last_beat", 64'(axi_last), 1);
    fm_data = 51'h3_3333_3333_3333;
    fm_vld  = 1'b1;
    step();
    fm_vld = 1'b0;
    chk("full_pop_fill15", 64'(fill), 15);
    n = 0;
    while (axi_vld && n < 40) begin
      step();
      n++;
    end
    chk("drain_done", 64'(axi_vld), 0);

    // Mode change with 5 stored samples flushes the buffer.
    axi_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fm_data = SB_DW'(64'h100 + 64'(i));
      fm_vld  = 1'b1;
      step();
    end
    fm_vld = 1'b0;
    chk("mc_fill5", 64'(fill), 5);
    pb_mode = 2'b00;
    step();
    chk("mc_fill0", 64'(fill), 0);
    chk("mc_vld0", 64'(axi_vld), 0);

    // Triggered mode: trig after 10 armed cycles, capture until full.
    pb_mode = 2'b10;
    step();
    fm_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fm_data = SB_DW'(64'h4_0000_0000_0000 + 64'(i));
      step();
    end
    chk("armed_no_capture", 64'(fill), 0);
    trig    = 1'b1;
    fm_data = SB_DW'(64'h4_0000_0000_1000);
    step();
    trig = 1'b0;
    chk("trig_fill1", 64'(fill), 1);
    for (int i = 0; i < 15; i++) begin
      fm_data = SB_DW'(64'h4_0000_0000_1001 + 64'(i));
      step();
    end
    chk("trig_fill16", 64'(fill), 16);
    chk("trig_frozen", 64'(frozen), 1);
    axi_rdy = 1'b1;
    n = 0;
    beats = 0;
    while (frozen && n < 100) begin
      if (axi_vld && axi_rdy) beats++;
      fm_data = SB_DW'(64'h5_0000_0000_0000 + 64'(n));
      step();
      n++;
    end
    chk("trig_beats32", 64'(beats), 32);
    chk("trig_unfrozen", 64'(frozen), 0);
    chk("trig_fill_after", 64'(fill), 0);
    repeat (3) step();
    chk("rearmed_no_capture", 64'(fill), 0);
    fm_vld = 1'b0;

    // Reset during beat 0 of a sample.
    pb_mode = 2'b01;
    step();
    axi_rdy = 1'b0;
    fm_data = 51'h7_FFFF_1234_5678;
    fm_vld  = 1'b1;
    step();
    fm_vld = 1'b0;
    step();
    chk("pre_rst_vld", 64'(axi_vld), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 64'(axi_vld), 0);
    chk("mid_rst_last", 64'(axi_last), 0);
    chk("mid_rst_data", 64'(axi_data), 0);
    chk("mid_rst_fill", 64'(fill), 0);
    chk("mid_rst_frozen", 64'(frozen), 0);
    step();
    rst_n = 1'b1;
    step();
    fm_data = 51'h1_2345_89AB_CDEF;
    fm_vld  = 1'b1;
    axi_rdy = 1'b1;
    step();
    fm_vld = 1'b0;
    chk("post_rst_fill", 64'(fill), 1);
    chk("post_rst_beat0", 64'(axi_data), 64'h89AB_CDEF);
    chk("post_rst_last0", 64'(axi_last), 0);
    step();
    chk("post_rst_beat1", 64'(axi_data), 64'h0001_2345);
    chk("post_rst_last1", 64'(axi_last), 1);
    step();
    chk("post_rst_empty", 64'(axi_vld), 0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
